// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the sequencer, decoder, memories and datapath.
// Pure wiring, no latency of its own.
// Readies come from the memories; requests hold until the matching ready (or a fault) arrives.
interface instr_sequencer_if #(
   parameter int CNT_W = 16
);
   // decoder / control inputs to the sequencer
   logic             start;
   logic [5:0]       opcode;
   logic [1:0]       reg_write;
   logic             dmem_enable;
   logic             dmem_write_enable;
   logic [4:0]       br_op;
   logic             imem_ready;
   logic             dmem_ready;
   // strobes and status from the sequencer
   logic             imem_req;
   logic             ir_write;
   logic             alu_en;
   logic             flag_write;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_write;
   logic             pc_write;
   logic [2:0]       state;
   logic             halted;
   logic             fault;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  start, opcode, reg_write, dmem_enable, dmem_write_enable, br_op,
             imem_ready, dmem_ready,
      output imem_req, ir_write, alu_en, flag_write, dmem_req, dmem_we,
             rf_write, pc_write, state, halted, fault, instr_count
   );

   modport slave (
      output start, opcode, reg_write, dmem_enable, dmem_write_enable, br_op,
             imem_ready, dmem_ready,
      input  imem_req, ir_write, alu_en, flag_write, dmem_req, dmem_we,
             rf_write, pc_write, state, halted, fault, instr_count
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP mini-RISC core.
// Strobes are combinational from the registered state and same-cycle inputs; 3-5 cycles per instruction.
// Memory requests hold until ready; TIMEOUT wait cycles without ready halts with fault set.
module instr_sequencer #(
   parameter int         TIMEOUT     = 16,
   parameter logic [5:0] HALT_OPCODE = 6'd63,
   parameter int         CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   instr_sequencer_if.master     bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam int              WC_W      = $clog2(TIMEOUT) + 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

   state_t           state_q;
   logic [WC_W-1:0]  wait_cnt;
   logic             fault_q;
   logic [CNT_W-1:0] count_q;

   logic imem_req, ir_write, alu_en, flag_write;
   logic dmem_req, dmem_we, rf_write, pc_write;

   // Strobe decode from current state plus this cycle's decoder fields and readies
   always_comb begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      alu_en     = 1'b0;
      flag_write = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_write   = 1'b0;
      pc_write   = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            ir_write = bus.imem_ready;
         end
         EXEC: begin
            alu_en     = 1'b1;
            // only plain ALU ops touch carry/zero; branches and link do not
            flag_write = (bus.reg_write == 2'b01) && (bus.br_op == 5'd0);
            // nothing left to do after EXEC: branches, nop and invalid retire here
            pc_write   = !bus.dmem_enable && (bus.reg_write == 2'b00);
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = bus.dmem_write_enable;
            // loads retire in WB, everything else retires on the ready cycle
            pc_write = bus.dmem_ready && (bus.reg_write != 2'b10);
         end
         WB: begin
            rf_write = 1'b1;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // State transitions, memory wait timeout, fault latch and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wait_cnt <= '0;
         fault_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q  <= FETCH;
                  wait_cnt <= '0;
               end
            end
            FETCH: begin
               // a ready in the last allowed wait cycle still completes the fetch
               if (bus.imem_ready) begin
                  state_q <= DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  state_q <= HALT;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DECODE: begin
               if (bus.opcode == HALT_OPCODE) state_q <= HALT;
               else                           state_q <= EXEC;
            end
            EXEC: begin
               if (bus.dmem_enable) begin
                  state_q  <= MEM;
                  wait_cnt <= '0;
               end else if (bus.reg_write != 2'b00) begin
                  state_q <= WB;
               end else begin
                  state_q  <= FETCH;
                  wait_cnt <= '0;
               end
            end
            MEM: begin
               if (bus.dmem_ready) begin
                  if (bus.reg_write == 2'b10) begin
                     state_q <= WB;
                  end else begin
                     state_q  <= FETCH;
                     wait_cnt <= '0;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  state_q <= HALT;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WB: begin
               state_q  <= FETCH;
               wait_cnt <= '0;
            end
            default: state_q <= HALT;  // HALT and the unused code 7 are sticky until reset
         endcase
         if (pc_write) count_q <= count_q + 1'b1;
      end
   end

   assign bus.imem_req    = imem_req;
   assign bus.ir_write    = ir_write;
   assign bus.alu_en      = alu_en;
   assign bus.flag_write  = flag_write;
   assign bus.dmem_req    = dmem_req;
   assign bus.dmem_we     = dmem_we;
   assign bus.rf_write    = rf_write;
   assign bus.pc_write    = pc_write;
   assign bus.state       = state_q;
   assign bus.halted      = state_q[2] & state_q[1];  // codes 6 and 7
   assign bus.fault       = fault_q;
   assign bus.instr_count = count_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the KGP mini-RISC core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and optional WB. It drives the instruction-memory and data-memory request handshakes, and the strobes for IR, PC, register file and flags. It consumes the decoded control fields (`reg_write`, `dmem_enable`, `dmem_write_enable`, `br_op`) produced by the combinational decoder and sits between that decoder and the datapath/memories.

## Interface
- `TIMEOUT`, 16: max cycles spent waiting for a memory `*_ready` before a fault halt (≥2).
- `HALT_OPCODE`, 6'd63: opcode that stops the sequencer.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE and begin fetching.
- `opcode` in 6: IR opcode field, valid from DECODE onward.
- `reg_write` in 2: decoder field (00 none, 01 ALU result, 10 load, 11 link).
- `dmem_enable` in 1: decoder field, instruction uses data memory.
- `dmem_write_enable` in 1: decoder field, store.
- `br_op` in 5: decoder branch code; nonzero means branch.
- `imem_ready` in 1: instruction memory has data.
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `ir_write` out 1: load IR.
- `alu_en` out 1: ALU/branch-evaluate cycle.
- `flag_write` out 1: update carry/zero flags.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write.
- `rf_write` out 1: register file write.
- `pc_write` out 1: PC update (next-PC mux selected externally by `br_op`).
- `state` out 3: current state encoding.
- `halted` out 1: in HALT.
- `fault` out 1: halted due to memory timeout.
- `instr_count` out `CNT_W`: instructions retired.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7 map to HALT.
- State, `wait_cnt`, `fault` and `instr_count` are registered. Strobes are decoded from the current state and same-cycle inputs.
- **IDLE**: all strobes 0. If `start`=1, go to FETCH. `start` is ignored in every other state.
- **FETCH**: `imem_req`=1.
  - `imem_ready`=1: `ir_write`=1, next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: one cycle, no strobes.
  - `opcode`==`HALT_OPCODE`: go to HALT with `fault`=0.
  - Otherwise go to EXEC.
- **EXEC**: one cycle, `alu_en`=1. `flag_write`=1 iff `reg_write`==01 and `br_op`==0. Next state:
  - `dmem_enable`=1: MEM.
  - else `reg_write`!=00: WB.
  - else: `pc_write`=1 and go to FETCH. This covers b, br, bcy, bncy, bltz, bz, bnz, and the invalid/nop default.
- **MEM**: `dmem_req`=1, `dmem_we`=`dmem_write_enable`.
  - On `dmem_ready`=1 with `reg_write`==10: next state WB.
  - On `dmem_ready`=1 otherwise: `pc_write`=1, next state FETCH.
- **WB**: `rf_write`=1, `pc_write`=1, next state FETCH.
- **HALT**: all strobes 0, `halted`=1. Only `rst` exits.
- **Timeout**:
  - `wait_cnt` clears on entry to FETCH or MEM and increments each cycle the awaited ready is low.
  - If ready is low while `wait_cnt`==`TIMEOUT`-1, the next state is HALT and `fault` is set to 1.
- **Retire counter**: `instr_count` increments by 1 on every cycle with `pc_write`=1 and wraps modulo 2^`CNT_W`.

## Timing
- Reset values: state=IDLE, `wait_cnt`=0, `instr_count`=0, `fault`=0, `halted`=0. All strobes are 0 in the cycle after reset.
- Reset mid-operation (e.g. during MEM with `dmem_req` high): at the reset edge the state becomes IDLE and all strobes drop. No `pc_write` or `rf_write` completes.
- Cycles per instruction with zero-wait memories:
  - branch / nop: 3 (F, D, E).
  - ALU, bl: 4 (F, D, E, W).
  - sw: 4 (F, D, E, M).
  - lw: 5 (F, D, E, M, W).
- Each memory wait cycle adds 1.
- `ir_write` and `pc_write` are single-cycle pulses, exactly one each per retired instruction.
- A ready arriving in the same cycle the timeout would fire wins: the access completes normally.
- `imem_req`/`dmem_req` stay high continuously until ready or timeout. The sequencer never drops a request early.

## Test plan
- **ALU instruction**: reset, `start`=1 for one cycle, ALU op (`reg_write`=01, `br_op`=0), readies tied high → states 1,2,3,5,1. Required: `flag_write` pulse in EXEC, `rf_write` and `pc_write` in WB, then `instr_count`=1.
- **Load**: `dmem_enable`=1, `reg_write`=10, `dmem_ready` low for 3 MEM cycles → MEM lasts 4 cycles with `dmem_we`=0, followed by WB. Total 8 cycles, `instr_count`=1.
- **Branches and store**:
  - Store: `dmem_write_enable`=1, `reg_write`=00 → `dmem_we`=1, `pc_write` asserted in the MEM ready cycle, no WB.
  - Branch `br_op`=00001 → 3-cycle instruction with no `rf_write`.
  - `bl` (`reg_write`=11) → passes through WB.
- **Timeout**: `imem_ready` held low with `TIMEOUT`=16 → 16 FETCH cycles, then state=6, `halted`=1, `fault`=1. A further `start` is ignored.
- **HALT opcode**: `opcode`=63 → DECODE goes to HALT with `fault`=0 and no `pc_write`.
- **Reset mid-MEM and counter wrap**:
  - `rst` during a MEM wait → IDLE on the next edge, `dmem_req`=0, counters 0.
  - With `CNT_W`=4, 16 instructions retired → `instr_count` wraps to 0.
